vaccine_hit_tracker: RTL and testbench
======================================

// Module: vaccine_hit_tracker
// PURPOSE
//  Consumer end of the collision interface produced by the game controller.
//  - Takes the per-frame single-hit pulse and the 4-bit vaccine collision index.
//  - Keeps the alive mask for the NUM_VACCINES vaccines, a saturating score and an error counter.
//  - Raises a timed level-clear indication, then reloads the mask.
//  - Feeds the vaccine drawers (mask) and the score display.
// PARAMETERS
//  NUM_VACCINES  10  vaccine slots; valid indices 0..NUM_VACCINES-1
//  SCORE_W       10  score width, saturates at 2**SCORE_W-1
//  POINTS         5  score increment per accepted hit
//  CLEAR_FRAMES  60  frames level_clear stays high before the mask reloads
//  FLASH_FRAMES   8  frames hit_flash stays high (HIT_STRETCH_EN only)
// PORTS
//  clk           in   1             system clock
//  reset         in   1             asynchronous, active-high reset
//  startOfFrame  in   1             1-cycle pulse per frame
//  hit_valid     in   1             single-hit pulse, at most 1 cycle per frame
//  hit_index     in   4             vaccine index of the collision; 4'hF = error code
//  vaccine_alive out  NUM_VACCINES  bit i = vaccine i is drawn
//  score         out  SCORE_W       accumulated score
//  hit_pulse     out  1             1-cycle pulse per accepted hit
//  level_clear   out  1             high during the clear period
//  err_cnt       out  4             count of invalid indices, saturating at 15
//  hit_flash     out  1             visual hit feedback (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, immediate):
//  - state=IDLE, vaccine_alive=all 1s, score=0, err_cnt=0.
//  - hit_pulse, level_clear, hit_flash = 0.
//  FSM states: IDLE, ARMED, HIT, LOCKED, CLEAR.
//  - IDLE: hits ignored. startOfFrame -> ARMED.
//  - ARMED, hit_valid=1:
//    - hit_index < NUM_VACCINES and alive[index]=1: latch index -> HIT.
//    - hit_index >= NUM_VACCINES (incl. 4'hF): err_cnt+1 (saturating), stay ARMED.
//    - index valid but vaccine already dead: ignored, no count, stay ARMED.
//  - HIT (exactly 1 cycle):
//    - clear alive[idx], score += POINTS (saturating), hit_pulse=1.
//    - -> CLEAR if the mask becomes 0, else -> LOCKED.
//  - LOCKED: all hits ignored (one hit per frame). startOfFrame -> ARMED.
//  - CLEAR: level_clear=1.
//    - Count CLEAR_FRAMES startOfFrame pulses, then in the same cycle set vaccine_alive=all 1s, level_clear=0, -> ARMED.
//    - Hits ignored.
//  Latency: hit_valid to vaccine_alive/score/hit_pulse update = 2 clk edges (latch at edge 1, commit at edge 2).
//  Simultaneous events:
//  - ARMED, startOfFrame with hit_valid: the hit is accepted.
//  - LOCKED, startOfFrame with hit_valid: -> ARMED and the hit is dropped.
//  - HIT with startOfFrame: the commit completes and the frame edge is not lost; the next state is ARMED, not LOCKED.
//  Score saturation: score + POINTS > max gives score = 2**SCORE_W-1; it never wraps.
//  Mid-operation reset: every state returns to the reset values immediately; a pending latched index is discarded.
// CONFIGURATION
//  HIT_STRETCH_EN defined:
//  - hit_flash goes 1 on the hit_pulse cycle.
//  - It stays 1 for FLASH_FRAMES startOfFrame pulses, then returns to 0.
//  - A new hit restarts the count.
//  - Reset clears it.
//  HIT_STRETCH_EN undefined: hit_flash is tied to 0 and no flash counter logic is built.
// STRUCTURE
//  game_pkg:
//  - NUM_VACCINES_DEF=10, IDX_ERR=4'hF, typedef enum logic[2:0] hit_state_t.
//  - typedef logic[3:0] vac_idx_t.
//  Sub-module frame_down_counter (params WIDTH, LOAD):
//  - inputs load, tick=startOfFrame; output done.
//  - One instance for CLEAR, plus one more under HIT_STRETCH_EN for the flash.
// TESTING
//  1 reset; 1 SOF; hit_valid with idx=3 -> after 2 edges: alive[3]=0, score=5, one hit_pulse.
//  2 same frame, second hit_valid with idx=4 -> ignored, alive[4]=1, score=5; next SOF then idx=4 -> score=10.
//  3 ARMED, hit_valid with idx=4'hF, then idx=12 -> err_cnt=2, mask and score unchanged, still ARMED.
//  4 hit all 10 vaccines over 10 frames -> level_clear=1; after 60 SOF: mask=10'h3FF, level_clear=0.
//  5 SCORE_W=4, POINTS=5, 4 hits -> score=15 (saturated); reset mid-CLEAR -> all outputs back to reset values.
//  6 HIT_STRETCH_EN defined: hit -> hit_flash=1 for exactly 8 SOF; undefined: hit_flash stays 0.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the vaccine collision path
package game_pkg;

  localparam int unsigned NUM_VACCINES_DEF = 10;

  typedef logic [3:0] vac_idx_t;

  // Index value the game controller sends when a collision could not be resolved.
  localparam vac_idx_t IDX_ERR = 4'hF;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    HIT,
    LOCKED,
    CLEAR
  } hit_state_t;

  // An index is unusable if it is the explicit error code or points past the last slot.
  function automatic logic idx_invalid(input vac_idx_t idx, input int unsigned num);
    return (idx == IDX_ERR) || (32'(idx) >= num);
  endfunction

endpackage

// File: rtl/frame_down_counter.sv
// rtl/frame_down_counter.sv - loadable frame counter, done pulses on the LOAD-th tick
module frame_down_counter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LOAD  = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over a coincident tick; done fires in the same cycle as the final tick.
  always_comb begin
    cnt_d = cnt_q;
    done  = 1'b0;
    if (load) begin
      cnt_d = WIDTH'(LOAD);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
      done  = (cnt_q == WIDTH'(1));
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vaccine_hit_tracker.sv
// rtl/vaccine_hit_tracker.sv - vaccine alive mask, score and level-clear tracking; HIT_STRETCH_EN adds hit_flash
module vaccine_hit_tracker
  import game_pkg::*;
#(
  parameter int unsigned NUM_VACCINES = NUM_VACCINES_DEF,
  parameter int unsigned SCORE_W      = 10,
  parameter int unsigned POINTS       = 5,
  parameter int unsigned CLEAR_FRAMES = 60,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    hit_valid,
  input  logic [3:0]              hit_index,
  output logic [NUM_VACCINES-1:0] vaccine_alive,
  output logic [SCORE_W-1:0]      score,
  output logic                    hit_pulse,
  output logic                    level_clear,
  output logic [3:0]              err_cnt,
  output logic                    hit_flash
);

  localparam logic [NUM_VACCINES-1:0] ALL_ALIVE = '1;
  localparam logic [SCORE_W-1:0]      SCORE_MAX = '1;
  localparam int unsigned             CLR_W     = $clog2(CLEAR_FRAMES + 1);

  hit_state_t                state_q, state_d;
  vac_idx_t                  idx_q, idx_d;
  logic [NUM_VACCINES-1:0]   alive_q, alive_d;
  logic [SCORE_W-1:0]        score_q, score_d;
  logic [3:0]                err_q, err_d;
  logic                      hit_pulse_q, hit_pulse_d;

  logic [NUM_VACCINES-1:0]   hit_onehot, idx_onehot, alive_after;
  logic [SCORE_W:0]          score_sum;
  logic                      clear_load, clear_tick, clear_done;

  assign hit_onehot  = NUM_VACCINES'(1) << hit_index;
  assign idx_onehot  = NUM_VACCINES'(1) << idx_q;
  assign alive_after = alive_q & ~idx_onehot;
  assign score_sum   = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);
  assign clear_tick  = startOfFrame && (state_q == CLEAR);

  frame_down_counter #(
    .WIDTH (CLR_W),
    .LOAD  (CLEAR_FRAMES)
  ) u_clear_cnt (
    .clk  (clk),
    .rst  (reset),
    .load (clear_load),
    .tick (clear_tick),
    .done (clear_done)
  );

  // Next-state and commit logic: latch in ARMED, commit mask/score in HIT, reload after CLEAR.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    alive_d     = alive_q;
    score_d     = score_q;
    err_d       = err_q;
    hit_pulse_d = 1'b0;
    clear_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (startOfFrame) state_d = ARMED;
      end
      ARMED: begin
        if (hit_valid) begin
          if (idx_invalid(hit_index, NUM_VACCINES)) begin
            if (err_q != 4'hF) err_d = err_q + 4'd1;
          end else if ((alive_q & hit_onehot) != '0) begin
            idx_d   = hit_index;
            state_d = HIT;
          end
        end
      end
      HIT: begin
        alive_d     = alive_after;
        score_d     = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
        hit_pulse_d = 1'b1;
        if (alive_after == '0) begin
          state_d    = CLEAR;
          clear_load = 1'b1;
        end else if (startOfFrame) begin
          state_d = ARMED;
        end else begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (startOfFrame) state_d = ARMED;
      end
      CLEAR: begin
        if (clear_done) begin
          alive_d = ALL_ALIVE;
          state_d = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any latched index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      alive_q     <= ALL_ALIVE;
      score_q     <= '0;
      err_q       <= '0;
      hit_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      alive_q     <= alive_d;
      score_q     <= score_d;
      err_q       <= err_d;
      hit_pulse_q <= hit_pulse_d;
    end
  end

  assign vaccine_alive = alive_q;
  assign score         = score_q;
  assign err_cnt       = err_q;
  assign hit_pulse     = hit_pulse_q;
  assign level_clear   = (state_q == CLEAR);

`ifdef HIT_STRETCH_EN
  localparam int unsigned FLASH_W = $clog2(FLASH_FRAMES + 1);

  logic flash_q, flash_d, flash_load, flash_done;

  assign flash_load = (state_q == HIT);

  frame_down_counter #(
    .WIDTH (FLASH_W),
    .LOAD  (FLASH_FRAMES)
  ) u_flash_cnt (
    .clk  (clk),
    .rst  (reset),
    .load (flash_load),
    .tick (startOfFrame),
    .done (flash_done)
  );

  // Flash rises with the hit commit and drops after the configured number of frames.
  always_comb begin
    flash_d = flash_q;
    if (flash_load)      flash_d = 1'b1;
    else if (flash_done) flash_d = 1'b0;
  end

  // Flash register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flash_q <= 1'b0;
    else       flash_q <= flash_d;
  end

  assign hit_flash = flash_q;
`else
  logic unused_flash_cfg;
  assign unused_flash_cfg = (FLASH_FRAMES == 0);
  assign hit_flash        = 1'b0;
`endif

endmodule

// File: tb/tb_vaccine_hit_tracker.sv
// tb/tb_vaccine_hit_tracker.sv - directed table, corner sequences and randomized model check
module tb_vaccine_hit_tracker;
  import game_pkg::*;

  localparam int NV        = 10;
  localparam int PTS       = 5;
  localparam int SCORE_MAX = 1023;
  localparam int SMALL_MAX = 15;
  localparam int CLR       = 60;
  localparam int FL        = 8;
`ifdef HIT_STRETCH_EN
  localparam bit FLASH_ON  = 1'b1;
`else
  localparam bit FLASH_ON  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          startOfFrame = 1'b0;
  logic          hit_valid = 1'b0;
  logic [3:0]    hit_index = 4'd0;
  logic [NV-1:0] vaccine_alive, s_alive;
  logic [9:0]    score;
  logic [3:0]    s_score;
  logic          hit_pulse, level_clear, hit_flash;
  logic          s_pulse, s_level, s_flash;
  logic [3:0]    err_cnt, s_err;

  always #5 clk = ~clk;

  vaccine_hit_tracker u_dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_valid(hit_valid),
    .hit_index(hit_index), .vaccine_alive(vaccine_alive), .score(score),
    .hit_pulse(hit_pulse), .level_clear(level_clear), .err_cnt(err_cnt), .hit_flash(hit_flash)
  );

  vaccine_hit_tracker #(.SCORE_W(4)) u_small (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_valid(hit_valid),
    .hit_index(hit_index), .vaccine_alive(s_alive), .score(s_score),
    .hit_pulse(s_pulse), .level_clear(s_level), .err_cnt(s_err), .hit_flash(s_flash)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: slots, points and frame budgets as plain integers.
  bit m_alive[NV];
  int m_score, m_small, m_err, m_pending, m_clear_left, m_flash_left;
  bit m_armed, m_pulse;

  function automatic logic [NV-1:0] m_mask();
    logic [NV-1:0] m;
    for (int i = 0; i < NV; i++) m[i] = m_alive[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) m_alive[i] = 1'b1;
    m_score = 0; m_small = 0; m_err = 0; m_pending = -1;
    m_clear_left = 0; m_flash_left = 0; m_armed = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit h, input int idx);
    bit committed;
    committed = 1'b0;
    m_pulse   = 1'b0;
    if (m_pending >= 0) begin
      m_alive[m_pending] = 1'b0;
      m_score   = (m_score + PTS > SCORE_MAX) ? SCORE_MAX : m_score + PTS;
      m_small   = (m_small + PTS > SMALL_MAX) ? SMALL_MAX : m_small + PTS;
      m_pulse   = 1'b1;
      committed = 1'b1;
      m_pending = -1;
      if (m_mask() == '0) begin
        m_clear_left = CLR;
        m_armed      = 1'b0;
      end else begin
        m_armed = s;
      end
    end else if (m_clear_left > 0) begin
      if (s) begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          for (int i = 0; i < NV; i++) m_alive[i] = 1'b1;
          m_armed = 1'b1;
        end
      end
    end else if (!m_armed) begin
      if (s) m_armed = 1'b1;
    end else if (h) begin
      if (idx >= NV) begin
        if (m_err < 15) m_err++;
      end else if (m_alive[idx]) begin
        m_pending = idx;
        m_armed   = 1'b0;
      end
    end
    if (committed) m_flash_left = FL;
    else if (s && m_flash_left > 0) m_flash_left--;
  endtask

  task automatic step(input bit s, input bit h, input logic [3:0] idx);
    startOfFrame = s; hit_valid = h; hit_index = idx;
    @(posedge clk); #1;
    model_step(s, h, int'(idx));
    startOfFrame = 1'b0; hit_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, " alive"}, 32'(vaccine_alive), 32'(m_mask()));
    check({tag, " score"}, 32'(score), 32'(m_score));
    check({tag, " small_score"}, 32'(s_score), 32'(m_small));
    check({tag, " hit_pulse"}, 32'(hit_pulse), 32'(m_pulse));
    check({tag, " level_clear"}, 32'(level_clear), 32'(m_clear_left > 0));
    check({tag, " err_cnt"}, 32'(err_cnt), 32'(m_err));
    check({tag, " hit_flash"}, 32'(hit_flash), 32'(FLASH_ON && (m_flash_left > 0)));
  endtask

  typedef struct {
    bit            sof;
    bit            hv;
    logic [3:0]    idx;
    logic [NV-1:0] alive;
    int            score;
    bit            pulse;
    int            err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd0,    10'h3FF, 0,  1'b0, 0};
    vecs[1]  = '{1'b0, 1'b1, 4'd3,    10'h3FF, 0,  1'b0, 0};
    vecs[2]  = '{1'b0, 1'b0, 4'd0,    10'h3F7, 5,  1'b1, 0};
    vecs[3]  = '{1'b0, 1'b1, 4'd4,    10'h3F7, 5,  1'b0, 0};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,    10'h3F7, 5,  1'b0, 0};
    vecs[5]  = '{1'b1, 1'b0, 4'd0,    10'h3F7, 5,  1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 4'd4,    10'h3F7, 5,  1'b0, 0};
    vecs[7]  = '{1'b1, 1'b0, 4'd0,    10'h3E7, 10, 1'b1, 0};
    vecs[8]  = '{1'b0, 1'b1, IDX_ERR, 10'h3E7, 10, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b1, 4'd12,   10'h3E7, 10, 1'b0, 2};
    vecs[10] = '{1'b0, 1'b1, 4'd3,    10'h3E7, 10, 1'b0, 2};
    vecs[11] = '{1'b0, 1'b1, 4'd0,    10'h3E7, 10, 1'b0, 2};
    vecs[12] = '{1'b0, 1'b0, 4'd0,    10'h3E6, 15, 1'b1, 2};
    vecs[13] = '{1'b0, 1'b1, 4'd1,    10'h3E6, 15, 1'b0, 2};
    vecs[14] = '{1'b1, 1'b1, 4'd1,    10'h3E6, 15, 1'b0, 2};
    vecs[15] = '{1'b1, 1'b1, 4'd1,    10'h3E6, 15, 1'b0, 2};
    vecs[16] = '{1'b0, 1'b0, 4'd0,    10'h3E4, 20, 1'b1, 2};

    do_reset();
    check("reset alive", 32'(vaccine_alive), 32'h3FF);
    check("reset score", 32'(score), 32'd0);
    check("reset err_cnt", 32'(err_cnt), 32'd0);
    check("reset hit_pulse", 32'(hit_pulse), 32'd0);
    check("reset level_clear", 32'(level_clear), 32'd0);
    check("reset hit_flash", 32'(hit_flash), 32'd0);

    // Hits before the first frame edge are ignored.
    step(1'b0, 1'b1, 4'd2);
    check("idle alive", 32'(vaccine_alive), 32'h3FF);
    step(1'b0, 1'b0, 4'd0);
    check("idle score", 32'(score), 32'd0);

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].sof, vecs[i].hv, vecs[i].idx);
      check($sformatf("vec%0d alive", i), 32'(vaccine_alive), 32'(vecs[i].alive));
      check($sformatf("vec%0d score", i), 32'(score), 32'(vecs[i].score));
      check($sformatf("vec%0d hit_pulse", i), 32'(hit_pulse), 32'(vecs[i].pulse));
      check($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].err));
      check($sformatf("vec%0d level_clear", i), 32'(level_clear), 32'd0);
    end
    check("small score saturated", 32'(s_score), 32'd15);

    // Finish the level one vaccine per frame.
    for (int i = 0; i < NV; i++) begin
      if (m_alive[i]) begin
        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b0, 4'd0);
      end
    end
    check("clear level_clear", 32'(level_clear), 32'd1);
    check("clear alive", 32'(vaccine_alive), 32'd0);
    check("clear score", 32'(score), 32'd50);
    check("clear small score", 32'(s_score), 32'd15);
    step(1'b0, 1'b1, 4'd5);
    step(1'b0, 1'b0, 4'd0);
    check("clear ignores hit", 32'(score), 32'd50);
    for (int f = 1; f < CLR; f++) begin
      step(1'b1, 1'b0, 4'd0);
      step(1'b0, 1'b0, 4'd0);
    end
    check("clear 59 frames level", 32'(level_clear), 32'd1);
    check("clear 59 frames alive", 32'(vaccine_alive), 32'd0);
    step(1'b1, 1'b0, 4'd0);
    check("reload alive", 32'(vaccine_alive), 32'h3FF);
    check("reload level_clear", 32'(level_clear), 32'd0);

    // Flash stretch across frame edges.
    step(1'b0, 1'b1, 4'd0);
    step(1'b0, 1'b0, 4'd0);
    check("flash pulse", 32'(hit_pulse), 32'd1);
    check("flash start", 32'(hit_flash), 32'(FLASH_ON));
    for (int k = 1; k <= FL; k++) begin
      step(1'b1, 1'b0, 4'd0);
      check($sformatf("flash sof%0d", k), 32'(hit_flash), 32'(FLASH_ON && (k < FL)));
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bit s, h;
      logic [3:0] idx;
      s   = ($urandom_range(0, 3) == 0);
      h   = ($urandom_range(0, 2) == 0);
      idx = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      step(s, h, idx);
      check_model($sformatf("rnd%0d", c));
    end

    // Asynchronous reset in the middle of a clear period.
    do_reset();
    step(1'b1, 1'b0, 4'd0);
    for (int i = 0; i < NV; i++) begin
      step(1'b0, 1'b1, 4'(i));
      step(1'b1, 1'b0, 4'd0);
    end
    for (int f = 0; f < 5; f++) step(1'b1, 1'b0, 4'd0);
    check("preclr level_clear", 32'(level_clear), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async alive", 32'(vaccine_alive), 32'h3FF);
    check("async score", 32'(score), 32'd0);
    check("async small score", 32'(s_score), 32'd0);
    check("async level_clear", 32'(level_clear), 32'd0);
    check("async err_cnt", 32'(err_cnt), 32'd0);
    check("async hit_flash", 32'(hit_flash), 32'd0);
    check("async hit_pulse", 32'(hit_pulse), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step(1'b0, 1'b0, 4'd0);
    check_model("post-reset");
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd7);
    step(1'b0, 1'b0, 4'd0);
    check_model("post-reset hit");
    check("post-reset hit alive", 32'(vaccine_alive), 32'h37F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
